// File: rtl/alarm_controller.sv
// alarm_controller: alarm time storage, set-mode editing, and ring/snooze/auto-stop sequencing
module alarm_controller #(
  parameter int RING_SECONDS   = 60,
  parameter int SNOOZE_SECONDS = 300,
  parameter int ALARM_RST_HOUR = 7,
  parameter int ALARM_RST_MIN  = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] current_hour,
  input  logic [7:0] current_minute,
  input  logic [7:0] current_second,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_arm,
  input  logic       btn_stop,
  input  logic       btn_snooze,
  output logic [7:0] alarm_hour,
  output logic [7:0] alarm_minute,
  output logic       armed,
  output logic [1:0] edit_mode,
  output logic       ringing,
  output logic       snoozing,
  output logic       buzzer
);
  typedef enum logic [2:0] {IDLE, EDIT_HOUR, EDIT_MIN, RINGING, SNOOZE} state_t;
  localparam logic [7:0]  RING_LAST = 8'(RING_SECONDS - 1);
  localparam logic [15:0] SNZ_LAST  = 16'(SNOOZE_SECONDS - 1);
  state_t      state, state_n;
  logic [7:0]  prev_second, ring_cnt, ring_cnt_n, alarm_hour_n, alarm_minute_n;
  logic [15:0] snz_cnt, snz_cnt_n;
  logic [1:0]  edit_mode_n;
  logic        armed_n, buzzer_n, sec_tick, trigger, in_alarm;
  assign sec_tick = current_second != prev_second;
  assign trigger  = armed && sec_tick && current_second == 8'd0 &&
                    current_hour == alarm_hour && current_minute == alarm_minute;
  assign in_alarm = state == RINGING || state == SNOOZE;
  // state and registered outputs; every output is loaded from its next-value computation
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      prev_second  <= 8'd0;
      ring_cnt     <= 8'd0;
      snz_cnt      <= 16'd0;
      alarm_hour   <= 8'(ALARM_RST_HOUR);
      alarm_minute <= 8'(ALARM_RST_MIN);
      armed        <= 1'b0;
      edit_mode    <= 2'd0;
      ringing      <= 1'b0;
      snoozing     <= 1'b0;
      buzzer       <= 1'b0;
    end else begin
      state        <= state_n;
      prev_second  <= current_second;
      ring_cnt     <= ring_cnt_n;
      snz_cnt      <= snz_cnt_n;
      alarm_hour   <= alarm_hour_n;
      alarm_minute <= alarm_minute_n;
      armed        <= armed_n;
      edit_mode    <= edit_mode_n;
      ringing      <= state_n == RINGING;
      snoozing     <= state_n == SNOOZE;
      buzzer       <= buzzer_n;
    end
  end
  // next state; a button that wins priority blocks the lower ones (stop > arm > snooze > trigger > mode)
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      state_n = btn_arm ? IDLE : trigger ? RINGING : btn_mode ? EDIT_HOUR : IDLE;
      EDIT_HOUR: state_n = btn_arm ? EDIT_HOUR : btn_mode ? EDIT_MIN : EDIT_HOUR;
      EDIT_MIN:  state_n = btn_arm ? EDIT_MIN : btn_mode ? IDLE : EDIT_MIN;
      RINGING:   state_n = (btn_stop || btn_arm) ? IDLE : btn_snooze ? SNOOZE :
                           (sec_tick && ring_cnt == RING_LAST) ? IDLE : RINGING;
      SNOOZE:    state_n = (btn_stop || btn_arm) ? IDLE :
                           (sec_tick && snz_cnt == SNZ_LAST) ? RINGING : SNOOZE;
      default:   state_n = IDLE;
    endcase
  end
  // next output values; counters clear whenever their state is (re)entered
  always_comb begin
    alarm_hour_n   = (state == EDIT_HOUR && btn_inc && !btn_arm && !btn_mode) ?
                     (alarm_hour == 8'd23 ? 8'd0 : alarm_hour + 8'd1) : alarm_hour;
    alarm_minute_n = (state == EDIT_MIN && btn_inc && !btn_arm && !btn_mode) ?
                     (alarm_minute == 8'd59 ? 8'd0 : alarm_minute + 8'd1) : alarm_minute;
    armed_n        = (btn_arm && !(in_alarm && btn_stop)) ? (in_alarm ? 1'b0 : ~armed) : armed;
    edit_mode_n    = state_n == EDIT_HOUR ? 2'd1 : state_n == EDIT_MIN ? 2'd2 : 2'd0;
    ring_cnt_n     = (state == RINGING && state_n == RINGING) ? ring_cnt + {7'd0, sec_tick} : 8'd0;
    snz_cnt_n      = (state == SNOOZE && state_n == SNOOZE) ? snz_cnt + {15'd0, sec_tick} : 16'd0;
    buzzer_n       = state_n != RINGING ? 1'b0 : state != RINGING ? 1'b1 : buzzer ^ sec_tick;
  end
endmodule

// File: tb/tb_alarm_controller.sv
// tb_alarm_controller: directed checks of editing, trigger, ring, snooze and reset behaviour
module tb_alarm_controller;
  logic       clk, reset;
  logic [7:0] current_hour, current_minute, current_second;
  logic       btn_mode, btn_inc, btn_arm, btn_stop, btn_snooze;
  logic [7:0] alarm_hour, alarm_minute;
  logic       armed, ringing, snoozing, buzzer;
  logic [1:0] edit_mode;
  int total = 0;
  int bad = 0;
  localparam logic [4:0] STOP = 5'b10000, ARM = 5'b01000, SNZ = 5'b00100, MODE = 5'b00010, INC = 5'b00001;

  alarm_controller #(.RING_SECONDS(3), .SNOOZE_SECONDS(2), .ALARM_RST_HOUR(7), .ALARM_RST_MIN(0)) dut (
    .clk(clk), .reset(reset),
    .current_hour(current_hour), .current_minute(current_minute), .current_second(current_second),
    .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_arm(btn_arm), .btn_stop(btn_stop), .btn_snooze(btn_snooze),
    .alarm_hour(alarm_hour), .alarm_minute(alarm_minute), .armed(armed), .edit_mode(edit_mode),
    .ringing(ringing), .snoozing(snoozing), .buzzer(buzzer)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [4:0] b);
    {btn_stop, btn_arm, btn_snooze, btn_mode, btn_inc} = b;
    step();
    {btn_stop, btn_arm, btn_snooze, btn_mode, btn_inc} = 5'b0;
  endtask

  task automatic set_time(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    current_hour = h;
    current_minute = m;
    current_second = s;
    step();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    {btn_stop, btn_arm, btn_snooze, btn_mode, btn_inc} = 5'b0;
    current_hour = 8'd0; current_minute = 8'd0; current_second = 8'd0;
    reset = 1'b1;
    step();
    step();
    chk("rst_hour", alarm_hour, 7);
    chk("rst_min", alarm_minute, 0);
    chk("rst_armed", armed, 0);
    chk("rst_edit", edit_mode, 0);
    chk("rst_ring", ringing, 0);
    chk("rst_snz", snoozing, 0);
    chk("rst_buzz", buzzer, 0);
    reset = 1'b0;
    step();
    // editing: 7 + 17 wraps to 0, 0 + 61 wraps to 1
    press(MODE);
    chk("edit1", edit_mode, 1);
    for (int i = 0; i < 17; i++) press(INC);
    chk("hour_wrap", alarm_hour, 0);
    press(MODE);
    chk("edit2", edit_mode, 2);
    for (int i = 0; i < 61; i++) press(INC);
    chk("min_wrap", alarm_minute, 1);
    press(MODE);
    chk("edit0", edit_mode, 0);
    chk("hour_kept", alarm_hour, 0);
    // disarmed alarm at matching time stays silent
    set_time(8'd0, 8'd0, 8'd59);
    set_time(8'd0, 8'd1, 8'd0);
    chk("disarmed_no_ring", ringing, 0);
    // move alarm to 06:30 and arm
    press(MODE);
    for (int i = 0; i < 6; i++) press(INC);
    press(MODE);
    for (int i = 0; i < 29; i++) press(INC);
    press(MODE);
    chk("set_hour", alarm_hour, 6);
    chk("set_min", alarm_minute, 30);
    press(ARM);
    chk("armed_on", armed, 1);
    // trigger, buzzer pattern, auto-stop after 3 ticks
    set_time(8'd6, 8'd29, 8'd59);
    chk("pre_trig", ringing, 0);
    set_time(8'd6, 8'd30, 8'd0);
    chk("trig_ring", ringing, 1);
    chk("trig_buzz", buzzer, 1);
    step();
    chk("no_tick_buzz", buzzer, 1);
    set_time(8'd6, 8'd30, 8'd1);
    chk("tick1_buzz", buzzer, 0);
    chk("tick1_ring", ringing, 1);
    set_time(8'd6, 8'd30, 8'd2);
    chk("tick2_buzz", buzzer, 1);
    set_time(8'd6, 8'd30, 8'd3);
    chk("auto_stop_ring", ringing, 0);
    chk("auto_stop_buzz", buzzer, 0);
    chk("auto_stop_armed", armed, 1);
    for (int s = 4; s < 60; s++) set_time(8'd6, 8'd30, 8'(s));
    chk("no_retrigger", ringing, 0);
    // snooze then resume after 2 ticks, then stop
    set_time(8'd6, 8'd29, 8'd59);
    set_time(8'd6, 8'd30, 8'd0);
    chk("trig2_ring", ringing, 1);
    press(SNZ);
    chk("snz_on", snoozing, 1);
    chk("snz_ring", ringing, 0);
    chk("snz_buzz", buzzer, 0);
    set_time(8'd6, 8'd30, 8'd1);
    chk("snz_tick1", snoozing, 1);
    set_time(8'd6, 8'd30, 8'd2);
    chk("snz_resume_ring", ringing, 1);
    chk("snz_resume_buzz", buzzer, 1);
    chk("snz_resume_snz", snoozing, 0);
    press(STOP);
    chk("stop_ring", ringing, 0);
    chk("stop_snz", snoozing, 0);
    // stop beats snooze in the same cycle
    set_time(8'd6, 8'd29, 8'd59);
    set_time(8'd6, 8'd30, 8'd0);
    chk("trig3_ring", ringing, 1);
    press(STOP | SNZ);
    chk("prio_ring", ringing, 0);
    chk("prio_snz", snoozing, 0);
    // arm while ringing stops and disarms
    set_time(8'd6, 8'd29, 8'd59);
    set_time(8'd6, 8'd30, 8'd0);
    chk("trig4_ring", ringing, 1);
    press(ARM);
    chk("arm_stop_ring", ringing, 0);
    chk("arm_stop_armed", armed, 0);
    set_time(8'd6, 8'd29, 8'd59);
    set_time(8'd6, 8'd30, 8'd0);
    chk("disarmed2_no_ring", ringing, 0);
    // armed but editing minutes: no trigger
    press(ARM);
    chk("rearmed", armed, 1);
    press(MODE);
    press(MODE);
    chk("in_edit_min", edit_mode, 2);
    set_time(8'd6, 8'd29, 8'd59);
    set_time(8'd6, 8'd30, 8'd0);
    chk("edit_no_ring", ringing, 0);
    press(MODE);
    chk("edit_exit", edit_mode, 0);
    // async reset while ringing
    set_time(8'd6, 8'd29, 8'd59);
    set_time(8'd6, 8'd30, 8'd0);
    chk("trig5_ring", ringing, 1);
    #1 reset = 1'b1;
    #1;
    chk("async_ring", ringing, 0);
    chk("async_buzz", buzzer, 0);
    chk("async_hour", alarm_hour, 7);
    chk("async_min", alarm_minute, 0);
    chk("async_armed", armed, 0);
    step();
    reset = 1'b0;
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
